// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-hazard bus between the datapath and hazard_fwd_unit.
// master: pipeline side (drives stage fields, reads selects/stall).
// slave:  hazard unit side.
// Macro HAZARD_STALL_CNT_EN adds the stall_cnt field.
interface hazard_fwd_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] rs_id, rt_id;
  logic              uses_rt_id, branch_id;
  logic [ADDR_W-1:0] rs_ex, rt_ex;
  logic              regwrite_ex, memread_ex;
  logic [ADDR_W-1:0] waddr_ex;
  logic              regwrite_mem, memread_mem;
  logic [ADDR_W-1:0] waddr_mem;
  logic              regwrite_wb;
  logic [ADDR_W-1:0] waddr_wb;
  logic [1:0]        fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id;
  logic              stall, bubble;
  logic [1:0]        stall_state;
  logic              hazard_err;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`else
  // CNT_W only sizes stall_cnt; reject a zero width even when it is absent.
  if (CNT_W == 0) begin : gBadCntW
    $error("hazard_fwd_unit_if: CNT_W must be nonzero");
  end
`endif

  modport master (
    output rs_id, rt_id, uses_rt_id, branch_id, rs_ex, rt_ex,
    output regwrite_ex, memread_ex, waddr_ex, regwrite_mem, memread_mem, waddr_mem,
    output regwrite_wb, waddr_wb,
    input  fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall, bubble, stall_state, hazard_err
`ifdef HAZARD_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, branch_id, rs_ex, rt_ex,
    input  regwrite_ex, memread_ex, waddr_ex, regwrite_mem, memread_mem, waddr_mem,
    input  regwrite_wb, waddr_wb,
    output fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall, bubble, stall_state, hazard_err
`ifdef HAZARD_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding for a 5-stage MIPS-style pipeline.
// EX operands forward from MEM/WB; ID branch compares forward from MEM (non-load)/WB.
// Load-use and branch hazards stall/bubble combinationally; a small FSM tracks the
// stall cause and a sticky flag catches runaway stall chains.
// Optional macro HAZARD_STALL_CNT_EN: saturating total stall-cycle counter (stall_cnt).
module hazard_fwd_unit #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_STALL = 3,
  parameter int unsigned CNT_W     = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_fwd_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StStallLu = 2'b01,
    StStallBr = 2'b10
  } stateE;

  localparam int unsigned ConsW = $clog2(MAX_STALL + 2);
  localparam logic [ConsW-1:0] ConsLim = ConsW'(MAX_STALL);
  localparam logic [ConsW-1:0] ConsMax = ConsW'(MAX_STALL + 1);

`ifndef HAZARD_STALL_CNT_EN
  if (CNT_W == 0) begin : gBadCntW
    $error("hazard_fwd_unit: CNT_W must be nonzero");
  end
`endif

  // Producer match: writing, not $0, and same register.
  function automatic logic hit(input logic we, input logic [ADDR_W-1:0] waddr,
                               input logic [ADDR_W-1:0] src);
    return we && (waddr != '0) && (waddr == src);
  endfunction

  stateE            state, stateNext;
  logic [ConsW-1:0] consCnt;
  logic             hazErr;
  logic             luHaz, brHaz, stallNow;

  // Forward selects: MEM beats WB; a load in MEM has no data yet for the ID compare.
  always_comb begin
    bus.fwd_a_ex = hit(bus.regwrite_mem, bus.waddr_mem, bus.rs_ex) ? 2'b10 :
                   hit(bus.regwrite_wb,  bus.waddr_wb,  bus.rs_ex) ? 2'b01 : 2'b00;
    bus.fwd_b_ex = hit(bus.regwrite_mem, bus.waddr_mem, bus.rt_ex) ? 2'b10 :
                   hit(bus.regwrite_wb,  bus.waddr_wb,  bus.rt_ex) ? 2'b01 : 2'b00;
    bus.fwd_a_id = (hit(bus.regwrite_mem, bus.waddr_mem, bus.rs_id) && !bus.memread_mem) ?
                   2'b10 : hit(bus.regwrite_wb, bus.waddr_wb, bus.rs_id) ? 2'b01 : 2'b00;
    bus.fwd_b_id = (hit(bus.regwrite_mem, bus.waddr_mem, bus.rt_id) && !bus.memread_mem) ?
                   2'b10 : hit(bus.regwrite_wb, bus.waddr_wb, bus.rt_id) ? 2'b01 : 2'b00;
  end

  // Hazard detection. A load still in EX is classed as load-use, so a load followed
  // by a dependent branch walks LU then BR and stalls exactly two cycles.
  always_comb begin
    luHaz = bus.memread_ex &&
            (hit(bus.regwrite_ex, bus.waddr_ex, bus.rs_id) ||
             (bus.uses_rt_id && hit(bus.regwrite_ex, bus.waddr_ex, bus.rt_id)));
    brHaz = bus.branch_id &&
            ((!bus.memread_ex &&
              (hit(bus.regwrite_ex, bus.waddr_ex, bus.rs_id) ||
               hit(bus.regwrite_ex, bus.waddr_ex, bus.rt_id))) ||
             (bus.memread_mem &&
              (hit(bus.regwrite_mem, bus.waddr_mem, bus.rs_id) ||
               hit(bus.regwrite_mem, bus.waddr_mem, bus.rt_id))));
    stallNow  = luHaz || brHaz;
    stateNext = brHaz ? StStallBr : (luHaz ? StStallLu : StRun);
  end

  assign bus.stall       = stallNow;
  assign bus.bubble      = stallNow;
  assign bus.stall_state = state;
  assign bus.hazard_err  = hazErr;

  // Stall-cause FSM, consecutive-stall counter and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StRun;
      consCnt <= '0;
      hazErr  <= 1'b0;
    end else begin
      state <= stateNext;
      if (stallNow) begin
        if (consCnt != ConsMax) consCnt <= consCnt + 1'b1;
        if (consCnt >= ConsLim) hazErr <= 1'b1;
      end else begin
        consCnt <= '0;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  assign bus.stall_cnt = stallCnt;

  // Total stalled edges, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallNow && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end
`endif

endmodule
